// File: rtl/tt_um_tkmic_serial_sub_pkg.sv
// Shared encodings for the tkmic bit-serial subtractor tile: FSM states and pin bit indices.
package tt_um_tkmic_serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ui_in bit positions
  localparam int UI_A     = 0;
  localparam int UI_B     = 1;
  localparam int UI_VALID = 2;
  localparam int UI_START = 3;

  // uio_out bit positions
  localparam int UIO_DIFF   = 0;
  localparam int UIO_BORROW = 1;
  localparam int UIO_DONE   = 2;
  localparam int UIO_BUSY   = 3;

  // Low nibble of uio drives status, high nibble stays input
  localparam logic [7:0] UIO_OE_VAL = 8'b0000_1111;

endpackage

// File: rtl/tkmic_sync_edge.sv
// N-stage synchronizer with a rising-edge detector on each synchronized bit.
// STAGES=0 samples the pins directly; the edge flop is always present.
module tkmic_sync_edge #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_s,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] w_s;
  logic [W-1:0] r_q;

  if (STAGES == 0) begin : g_direct
    assign w_s = i_d;
  end else begin : g_sync
    logic [STAGES-1:0][W-1:0] r_sync;

    // Shift pin samples through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= '0;
      end else begin
        r_sync[0] <= i_d;
        for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
    end

    assign w_s = r_sync[STAGES-1];
  end

  // Delay the synchronized level by one cycle for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= w_s;
  end

  assign o_s    = w_s;
  assign o_rise = w_s & ~r_q;

endmodule

// File: rtl/tt_um_tkmic_serial_sub.sv
// Bit-serial subtractor tile: takes A and B one bit per valid strobe, LSB first,
// keeps a borrow across bits and assembles a WIDTH-bit difference on uo_out.
module tt_um_tkmic_serial_sub
  import tt_um_tkmic_serial_sub_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [3:0]       w_s;
  logic [3:0]       w_rise;
  logic             w_a, w_b, w_valid_rise, w_start_rise;
  logic             w_d, w_borrow_nx;
  logic             w_clear, w_shift;
  state_e           r_state, w_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_borrow, r_diff, r_done, r_busy;
  logic             w_unused;

  // a/b share the strobe synchronizer so they line up with the valid edge
  tkmic_sync_edge #(.STAGES(SYNC_STAGES), .W(4)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (ui_in[3:0]),
    .o_s    (w_s),
    .o_rise (w_rise)
  );

  assign w_a          = w_s[UI_A];
  assign w_b          = w_s[UI_B];
  assign w_valid_rise = w_rise[UI_VALID];
  assign w_start_rise = w_rise[UI_START];

  assign w_d         = w_a ^ w_b ^ r_borrow;
  assign w_borrow_nx = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state;
  end

  // Next state and datapath strobes; start always beats a same-cycle valid
  always_comb begin
    w_state = r_state;
    w_clear = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state = ST_RUN;
          w_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_start_rise) begin
          w_clear = 1'b1;
        end else if (w_valid_rise) begin
          w_shift = 1'b1;
          if (r_count == LAST) w_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_start_rise) begin
          w_state = ST_RUN;
          w_clear = 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // Bit counter, borrow and result; count holds at the last index on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_result <= '0;
      r_borrow <= 1'b0;
      r_diff   <= 1'b0;
    end else if (w_clear) begin
      r_count  <= '0;
      r_result <= '0;
      r_borrow <= 1'b0;
      r_diff   <= 1'b0;
    end else if (w_shift) begin
      r_result <= r_result | (WIDTH'(w_d) << r_count);
      r_borrow <= w_borrow_nx;
      r_diff   <= w_d;
      if (r_count != LAST) r_count <= r_count + 1'b1;
    end
  end

  // Status flags registered from next state so they track the FSM without lag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state == ST_RUN);
      r_done <= (w_state == ST_DONE);
    end
  end

  assign uo_out = 8'(r_result);
  assign uio_oe = UIO_OE_VAL;

  // Pack status bits onto the bidirectional pins
  always_comb begin
    uio_out             = 8'h00;
    uio_out[UIO_DIFF]   = r_diff;
    uio_out[UIO_BORROW] = r_borrow;
    uio_out[UIO_DONE]   = r_done;
    uio_out[UIO_BUSY]   = r_busy;
  end

  assign w_unused = &{1'b0, ena, uio_in, ui_in[7:4], w_rise[UI_B:UI_A]};

endmodule

// File: tb/tb_tt_um_tkmic_serial_sub.sv
// Randomized self-checking bench for the bit-serial subtractor tile.
module tb_tt_um_tkmic_serial_sub;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_chk  = 0;
  int n_pass = 0;

  tt_um_tkmic_serial_sub #(.WIDTH(8), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Status nibble {busy, done, borrow, diff}
  function automatic logic [3:0] st(input logic busy, done, borrow, diff);
    return {busy, done, borrow, diff};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    ui_in[3] = 1'b1;
    cyc(1);
    ui_in[3] = 1'b0;
    cyc(SS + 2);
    chk("start_res", uo_out, 8'h00);
    chk("start_st", uio_out, {4'h0, st(1, 0, 0, 0)});
  endtask

  // Present one bit pair with valid held `hold` cycles; optionally check done latency
  task automatic send_bit(input logic a, input logic b, input int hold, input bit lat);
    ui_in[0] = a;
    ui_in[1] = b;
    ui_in[2] = 1'b1;
    for (int k = 1; k <= hold + SS + 2; k++) begin
      @(posedge clk); #1;
      if (lat && k <= SS + 1) chk("done_lat", uio_out[2], (k == SS + 1));
      if (k == hold) ui_in[2] = 1'b0;
    end
  endtask

  // Model: after k bits the tile holds (A-B) mod 2^k and borrow = (A mod 2^k) < (B mod 2^k)
  task automatic check_partial(input string tag, input int A, input int B, input int k);
    int m, r;
    logic bo, di;
    m  = (1 << k) - 1;
    r  = (A - B) & m;
    bo = (A & m) < (B & m);
    di = (r >> (k - 1)) & 1;
    chk({tag, "_res"}, uo_out, r);
    chk({tag, "_st"}, uio_out, {4'h0, st(k < 8, k == 8, bo, di)});
  endtask

  task automatic send_bits(input string tag, input logic [7:0] A, input logic [7:0] B,
                           input int nbits, input int hold, input bit lat_last);
    for (int i = 0; i < nbits; i++) begin
      send_bit(A[i], B[i], hold, lat_last && (i == 7));
      check_partial(tag, int'(A), int'(B), i + 1);
    end
  endtask

  task automatic run_word(input string tag, input logic [7:0] A, input logic [7:0] B, input int hold);
    pulse_start();
    send_bits(tag, A, B, 8, hold, 1'b0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int rh;

    ui_in = 8'h00;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'h0F);
    @(negedge clk) rst_n = 1'b1;
    cyc(2);

    // Basic subtraction with done latency on the last bit
    pulse_start();
    send_bits("t1", 8'h35, 8'h12, 8, 1, 1'b1);
    chk("t1_final", uo_out, 8'h23);

    // Negative result and wrap-around
    run_word("t2a", 8'h12, 8'h35, 1);
    chk("t2a_final", {uio_out[1], uo_out}, {1'b1, 8'hDD});
    run_word("t2b", 8'h00, 8'h01, 2);
    chk("t2b_final", {uio_out[1], uo_out}, {1'b1, 8'hFF});

    // Long valid level counts once per bit
    run_word("t3", 8'hFF, 8'hFF, 5);
    chk("t3_final", {uio_out[1], uo_out}, {1'b0, 8'h00});

    // Restart after a partial word
    pulse_start();
    send_bits("t4p", 8'h0F, 8'h01, 3, 1, 1'b0);
    run_word("t4", 8'h80, 8'h01, 1);
    chk("t4_final", {uio_out[1], uo_out}, {1'b0, 8'h7F});

    // Start and valid rise together: start wins, bit dropped
    pulse_start();
    send_bits("t5p", 8'h03, 8'h00, 2, 1, 1'b0);
    ui_in[0] = 1'b1; ui_in[1] = 1'b0;
    ui_in[2] = 1'b1; ui_in[3] = 1'b1;
    cyc(1);
    ui_in[2] = 1'b0; ui_in[3] = 1'b0;
    cyc(SS + 2);
    chk("t5_clr_res", uo_out, 8'h00);
    chk("t5_clr_st", uio_out, {4'h0, st(1, 0, 0, 0)});
    send_bits("t5", 8'h5A, 8'h3C, 8, 1, 1'b0);
    send_bit(1'b1, 1'b0, 1, 1'b0);
    send_bit(1'b0, 1'b1, 1, 1'b0);
    check_partial("t5_done", 32'h5A, 32'h3C, 8);
    chk("t5_oe", uio_oe, 8'h0F);

    // Randomized words against the model
    for (int t = 0; t < 10; t++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rh = $urandom_range(1, 3);
      run_word("rnd", ra, rb, rh);
      chk("rnd_borrow", uio_out[1], (ra < rb));
    end

    // Async reset mid-word, then valids ignored until start
    pulse_start();
    send_bits("t6p", 8'h0F, 8'h00, 4, 1, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("t6_rst_uo", uo_out, 8'h00);
    chk("t6_rst_uio", uio_out, 8'h00);
    chk("t6_rst_oe", uio_oe, 8'h0F);
    cyc(2);
    @(negedge clk) rst_n = 1'b1;
    cyc(2);
    send_bit(1'b1, 1'b0, 1, 1'b0);
    send_bit(1'b1, 1'b0, 1, 1'b0);
    chk("t6_idle_uo", uo_out, 8'h00);
    chk("t6_idle_uio", uio_out, 8'h00);
    run_word("t6", 8'h09, 8'h03, 1);
    chk("t6_final", uo_out, 8'h06);
    chk("t6_oe", uio_oe, 8'h0F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
